nand_async_seq: RTL and testbench

Sequencer for asynchronous-mode (legacy ONFI) NAND bus cycles through the NAND PHY's controller-facing interface. It accepts one command, address, write-data or read-data byte request at a time and expands it into a timed CE#/CLE/ALE/DQ/WE#/RE# sequence.
- WE# is produced via the PHY's ODDR clock path: wen_sel held 1, wen carries WE#.
- RE# is produced on the wrn line.
- Read bytes are captured from the PHY's combinational DQ read path.
- The block sits between the flash controller's command engine and the PHY, clocked in the PHY's clk0 domain.

---
 rtl/nand_async_seq.sv | 190 +++++++++++++++++++
 tb/tb_nand_async_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nand_async_seq.sv
// Async-mode NAND bus cycle sequencer: expands one CMD/ADDR/WDATA/RDATA byte
// request into a timed CE#/CLE/ALE/DQ/WE#/RE# sequence toward the PHY.
module nand_async_seq #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 3,
    parameter int T_HOLD  = 2
) (
    input  logic       v_clk0,
    input  logic       v_rst0,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_type,
    input  logic [7:0] req_data,
    input  logic       req_chip,
    input  logic       req_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       ctl_wp_n,
    output logic       busy,
    output logic       v_ctrl_cle,
    output logic       v_ctrl_ale,
    output logic       v_ctrl_wrn,
    output logic       v_ctrl_wpn,
    output logic [1:0] v_ctrl_cen,
    output logic       v_ctrl_wen,
    output logic       v_ctrl_wen_sel,
    output logic       v_dq_data_oe_n,
    output logic [7:0] v_wr_data_rise,
    output logic [7:0] v_wr_data_fall,
    output logic       v_dqs_oe_n,
    output logic       v_dqs_rst_n,
    input  logic [7:0] v_rd_data_comb,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [1:0] TYPE_CMD   = 2'd0;
    localparam logic [1:0] TYPE_ADDR  = 2'd1;
    localparam logic [1:0] TYPE_RDATA = 2'd3;

    state_t     state, nxt_state;
    logic [3:0] cnt, nxt_cnt;
    logic [1:0] typ_q, nxt_typ;
    logic       last_q, nxt_last;

    logic       nxt_req_ready, nxt_rsp_valid, nxt_busy;
    logic [7:0] nxt_rsp_data, nxt_wr_data;
    logic       nxt_cle, nxt_ale, nxt_wrn, nxt_wen, nxt_oe_n;
    logic [1:0] nxt_cen;
    logic       accept;

    assign accept    = (state == IDLE) && req_valid && req_ready;
    assign dbg_state = state;

    // Every output is the registered copy of its nxt_* value; the strobes only
    // toggle on phase boundaries so CLE/ALE/DQ are stable while they are low.
    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_typ       = typ_q;
        nxt_last      = last_q;
        nxt_req_ready = req_ready;
        nxt_rsp_valid = 1'b0;
        nxt_rsp_data  = rsp_data;
        nxt_wr_data   = v_wr_data_rise;
        nxt_cle       = v_ctrl_cle;
        nxt_ale       = v_ctrl_ale;
        nxt_wrn       = v_ctrl_wrn;
        nxt_wen       = v_ctrl_wen;
        nxt_oe_n      = v_dq_data_oe_n;
        nxt_cen       = v_ctrl_cen;

        unique case (state)
            IDLE: begin
                nxt_req_ready = 1'b1;
                if (accept) begin
                    nxt_state     = SETUP;
                    nxt_cnt       = 4'(T_SETUP - 1);
                    nxt_typ       = req_type;
                    nxt_last      = req_last;
                    nxt_req_ready = 1'b0;
                    nxt_cen       = req_chip ? 2'b01 : 2'b10;
                    nxt_cle       = (req_type == TYPE_CMD);
                    nxt_ale       = (req_type == TYPE_ADDR);
                    if (req_type == TYPE_RDATA) begin
                        nxt_oe_n = 1'b1;
                    end else begin
                        nxt_oe_n    = 1'b0;
                        nxt_wr_data = req_data;
                    end
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    nxt_state = PULSE;
                    nxt_cnt   = 4'(T_PULSE - 1);
                    if (typ_q == TYPE_RDATA) nxt_wrn = 1'b0;
                    else                     nxt_wen = 1'b0;
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            PULSE: begin
                if (cnt == 4'd0) begin
                    nxt_state = HOLD;
                    nxt_cnt   = 4'(T_HOLD - 1);
                    nxt_wen   = 1'b1;
                    nxt_wrn   = 1'b1;
                    // Sample DQ while RE# is still low; the byte is reported
                    // in the first HOLD cycle.
                    if (typ_q == TYPE_RDATA) begin
                        nxt_rsp_data  = v_rd_data_comb;
                        nxt_rsp_valid = 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    nxt_state     = IDLE;
                    nxt_req_ready = 1'b1;
                    nxt_cle       = 1'b0;
                    nxt_ale       = 1'b0;
                    nxt_oe_n      = 1'b1;
                    if (last_q) nxt_cen = 2'b11;
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            default: nxt_state = IDLE;
        endcase

        nxt_busy = (nxt_state != IDLE) || (nxt_cen != 2'b11);
    end

    always_ff @(posedge v_clk0) begin
        if (v_rst0) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            typ_q  <= 2'd0;
            last_q <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            typ_q  <= nxt_typ;
            last_q <= nxt_last;
        end
    end

    always_ff @(posedge v_clk0) begin
        if (v_rst0) begin
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= 8'd0;
            busy           <= 1'b0;
            v_ctrl_cle     <= 1'b0;
            v_ctrl_ale     <= 1'b0;
            v_ctrl_wrn     <= 1'b1;
            v_ctrl_wpn     <= 1'b0;
            v_ctrl_cen     <= 2'b11;
            v_ctrl_wen     <= 1'b1;
            v_ctrl_wen_sel <= 1'b1;
            v_dq_data_oe_n <= 1'b1;
            v_wr_data_rise <= 8'd0;
            v_wr_data_fall <= 8'd0;
            v_dqs_oe_n     <= 1'b1;
            v_dqs_rst_n    <= 1'b0;
        end else begin
            req_ready      <= nxt_req_ready;
            rsp_valid      <= nxt_rsp_valid;
            rsp_data       <= nxt_rsp_data;
            busy           <= nxt_busy;
            v_ctrl_cle     <= nxt_cle;
            v_ctrl_ale     <= nxt_ale;
            v_ctrl_wrn     <= nxt_wrn;
            v_ctrl_wpn     <= ctl_wp_n;
            v_ctrl_cen     <= nxt_cen;
            v_ctrl_wen     <= nxt_wen;
            v_ctrl_wen_sel <= 1'b1;
            v_dq_data_oe_n <= nxt_oe_n;
            v_wr_data_rise <= nxt_wr_data;
            v_wr_data_fall <= nxt_wr_data;
            v_dqs_oe_n     <= 1'b1;
            v_dqs_rst_n    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nand_async_seq.sv
// Directed bench for nand_async_seq: default timing instance (a_*) plus an
// instance with all phases set to one cycle (b_*).
module tb_nand_async_seq;

    localparam logic [1:0] CMD = 2'd0, ADDR = 2'd1, WDATA = 2'd2, RDATA = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req_type = 2'd0;
    logic [7:0] req_data = 8'd0;
    logic req_chip = 1'b0, req_last = 1'b0, ctl_wp_n = 1'b1;
    logic [7:0] rd_data = 8'h00;

    logic a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic a_req_ready, a_rsp_valid, a_busy, a_cle, a_ale, a_wrn, a_wpn, a_wen, a_wen_sel;
    logic a_oe_n, a_dqs_oe_n, a_dqs_rst_n;
    logic [1:0] a_cen, a_dbg;
    logic [7:0] a_rsp_data, a_wr_rise, a_wr_fall;
    logic b_req_ready, b_rsp_valid, b_busy, b_cle, b_ale, b_wrn, b_wpn, b_wen, b_wen_sel;
    logic b_oe_n, b_dqs_oe_n, b_dqs_rst_n;
    logic [1:0] b_cen, b_dbg;
    logic [7:0] b_rsp_data, b_wr_rise, b_wr_fall;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    nand_async_seq dut_a (
        .v_clk0(clk), .v_rst0(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_type(req_type), .req_data(req_data), .req_chip(req_chip), .req_last(req_last),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .ctl_wp_n(ctl_wp_n), .busy(a_busy),
        .v_ctrl_cle(a_cle), .v_ctrl_ale(a_ale), .v_ctrl_wrn(a_wrn), .v_ctrl_wpn(a_wpn),
        .v_ctrl_cen(a_cen), .v_ctrl_wen(a_wen), .v_ctrl_wen_sel(a_wen_sel),
        .v_dq_data_oe_n(a_oe_n), .v_wr_data_rise(a_wr_rise), .v_wr_data_fall(a_wr_fall),
        .v_dqs_oe_n(a_dqs_oe_n), .v_dqs_rst_n(a_dqs_rst_n), .v_rd_data_comb(rd_data),
        .dbg_state(a_dbg)
    );

    nand_async_seq #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut_b (
        .v_clk0(clk), .v_rst0(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_type(req_type), .req_data(req_data), .req_chip(req_chip), .req_last(req_last),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .ctl_wp_n(ctl_wp_n), .busy(b_busy),
        .v_ctrl_cle(b_cle), .v_ctrl_ale(b_ale), .v_ctrl_wrn(b_wrn), .v_ctrl_wpn(b_wpn),
        .v_ctrl_cen(b_cen), .v_ctrl_wen(b_wen), .v_ctrl_wen_sel(b_wen_sel),
        .v_dq_data_oe_n(b_oe_n), .v_wr_data_rise(b_wr_rise), .v_wr_data_fall(b_wr_fall),
        .v_dqs_oe_n(b_dqs_oe_n), .v_dqs_rst_n(b_dqs_rst_n), .v_rd_data_comb(rd_data),
        .dbg_state(b_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, presents one request for one edge, then
    // scrambles the request bus. Returns in cycle A+1.
    task automatic send_a(input logic [1:0] t, input logic [7:0] d, input logic c, input logic l);
        int guard = 0;
        while (!a_req_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("ready_wait", a_req_ready, 1'b1);
        req_type = t; req_data = d; req_chip = c; req_last = l;
        a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        req_type = ~t; req_data = ~d; req_chip = ~c; req_last = ~l;
    endtask

    // Runs one request on the default instance and records strobe/response
    // activity for cycles A+1..A+7 as bit masks; returns in cycle A+8.
    task automatic run_req(input logic [1:0] t, input logic [7:0] d, input logic c,
                           input logic l, output logic [7:0] wen_mask,
                           output logic [7:0] wrn_mask, output logic [7:0] rsp_mask,
                           output logic [7:0] rsp_d, output int hold_bad, output int cen_bad);
        logic [19:0] snap;
        wen_mask = '0; wrn_mask = '0; rsp_mask = '0; rsp_d = '0; hold_bad = 0; cen_bad = 0;
        send_a(t, d, c, l);
        chk("setup_cle", a_cle, t == CMD);
        chk("setup_ale", a_ale, t == ADDR);
        chk("setup_oe_n", a_oe_n, t == RDATA);
        if (t != RDATA) chk("setup_dq", {a_wr_rise, a_wr_fall}, {d, d});
        snap = {a_cle, a_ale, a_oe_n, a_wr_rise, a_wr_fall, 1'b0};
        for (int j = 1; j <= 7; j++) begin
            rd_data = (j >= 3 && j <= 5) ? 8'hA5 : 8'h3C;
            wen_mask[j] = ~a_wen;
            wrn_mask[j] = ~a_wrn;
            if (a_rsp_valid) begin
                rsp_mask[j] = 1'b1;
                rsp_d = a_rsp_data;
            end
            if ({a_cle, a_ale, a_oe_n, a_wr_rise, a_wr_fall, 1'b0} !== snap) hold_bad++;
            if (a_cen !== (c ? 2'b01 : 2'b10)) cen_bad++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wm, rm, vm, rd;
        int hb, cb, pulses, rsp_seen;
        logic [1:0] burst_t[7];
        logic [7:0] burst_d[7];
        burst_t = '{CMD, ADDR, ADDR, ADDR, ADDR, ADDR, CMD};
        burst_d = '{8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h01, 8'h30};

        // Reset values
        repeat (3) tick();
        chk("rst_cen", a_cen, 2'b11);
        chk("rst_wen_wrn", {a_wen, a_wrn, a_wen_sel}, 3'b111);
        chk("rst_ready", a_req_ready, 1'b0);
        chk("rst_busy_rsp", {a_busy, a_rsp_valid}, 2'b00);
        chk("rst_wpn", a_wpn, 1'b0);
        chk("rst_dqs", {a_dqs_oe_n, a_dqs_rst_n}, 2'b10);
        chk("rst_misc", {a_cle, a_ale, a_oe_n, a_wr_rise, a_rsp_data}, {3'b001, 16'h0});
        rst = 1'b0;
        repeat (10) tick();
        chk("idle_cen", a_cen, 2'b11);
        chk("idle_strobes", {a_wen, a_wrn, a_wen_sel, a_dqs_rst_n}, 4'b1110);
        chk("idle_ready_busy", {a_req_ready, a_busy}, 2'b10);
        chk("idle_wpn", a_wpn, 1'b1);
        chk("idle_b_ready", b_req_ready, 1'b1);

        // Single CMD 0xFF on chip 0, last
        run_req(CMD, 8'hFF, 1'b0, 1'b1, wm, rm, vm, rd, hb, cb);
        chk("cmd_wen_mask", wm, 8'b0011_1000);
        chk("cmd_wrn_mask", rm, 8'h00);
        chk("cmd_no_rsp", vm, 8'h00);
        chk("cmd_hold_stable", hb, 0);
        chk("cmd_cen", cb, 0);
        chk("cmd_end_ready", a_req_ready, 1'b1);
        chk("cmd_end_cen", a_cen, 2'b11);
        chk("cmd_end_idle", {a_busy, a_cle, a_oe_n}, 3'b001);

        // Command/address burst on chip 1, CE# held until the last request
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            run_req(burst_t[i], burst_d[i], 1'b1, i == 6, wm, rm, vm, rd, hb, cb);
            if (wm == 8'b0011_1000) pulses++;
            chk($sformatf("burst%0d_stable", i), hb, 0);
            chk($sformatf("burst%0d_cen", i), cb, 0);
            chk($sformatf("burst%0d_ready", i), a_req_ready, 1'b1);
            chk($sformatf("burst%0d_gap_cen", i), a_cen, (i == 6) ? 2'b11 : 2'b01);
            chk($sformatf("burst%0d_gap_ale", i), a_ale, 1'b0);
        end
        chk("burst_pulses", pulses, 7);
        chk("burst_end_busy", a_busy, 1'b0);

        // Read byte: RE# strobe, DQ released, single response
        run_req(RDATA, 8'h00, 1'b0, 1'b1, wm, rm, vm, rd, hb, cb);
        chk("rd_wrn_mask", rm, 8'b0011_1000);
        chk("rd_wen_mask", wm, 8'h00);
        chk("rd_rsp_mask", vm, 8'b0100_0000);
        chk("rd_rsp_data", rd, 8'hA5);
        chk("rd_stable", hb, 0);
        chk("rd_end_rsp", a_rsp_valid, 1'b0);

        // Reset on the second PULSE cycle of a WDATA
        send_a(WDATA, 8'h77, 1'b0, 1'b0);
        repeat (3) tick();
        chk("abort_in_pulse", a_wen, 1'b0);
        rst = 1'b1;
        tick();
        chk("abort_wen", a_wen, 1'b1);
        chk("abort_cen", a_cen, 2'b11);
        chk("abort_oe_n", a_oe_n, 1'b1);
        chk("abort_busy", {a_busy, a_req_ready}, 2'b00);
        rst = 1'b0;
        rsp_seen = 0;
        for (int j = 0; j < 10; j++) begin
            if (a_rsp_valid) rsp_seen++;
            tick();
        end
        chk("abort_no_rsp", rsp_seen, 0);
        run_req(CMD, 8'h70, 1'b0, 1'b1, wm, rm, vm, rd, hb, cb);
        chk("after_abort_wen", wm, 8'b0011_1000);
        chk("after_abort_rsp", vm, 8'h00);
        chk("after_abort_ready", a_req_ready, 1'b1);

        // Minimum timing instance: WDATA 0x5A on chip 1
        chk("b_pre_ready", b_req_ready, 1'b1);
        req_type = WDATA; req_data = 8'h5A; req_chip = 1'b1; req_last = 1'b1;
        b_req_valid = 1'b1;
        tick();
        b_req_valid = 1'b0;
        req_data = 8'h00;
        chk("b_setup", {b_wen, b_oe_n, b_cen, b_req_ready}, {1'b1, 1'b0, 2'b01, 1'b0});
        chk("b_setup_dq", {b_wr_rise, b_wr_fall}, 16'h5A5A);
        tick();
        chk("b_pulse_wen", b_wen, 1'b0);
        tick();
        chk("b_hold_wen", {b_wen, b_req_ready, b_oe_n}, 3'b100);
        tick();
        chk("b_ready_at_4", {b_req_ready, b_cen, b_busy}, {1'b1, 2'b11, 1'b0});

        // Write-protect level follows with one cycle of delay
        ctl_wp_n = 1'b0;
        chk("wpn_before", {a_wpn, b_wpn}, 2'b11);
        tick();
        chk("wpn_after", {a_wpn, b_wpn}, 2'b00);
        ctl_wp_n = 1'b1;
        tick();
        chk("wpn_back", {a_wpn, b_wpn}, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
